cam_pixel_packer: RTL and testbench



---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_colorbar_gen.sv | 27 ++
 rtl/cam_pixel_packer.sv | 199 +++++++++++++++++++
 tb/tb_cam_pixel_packer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state type, word geometry and colour-bar table for the camera pixel packer
package cam_pkg;

  typedef enum logic [1:0] {
    ST_SKIP,
    ST_WAIT_VS,
    ST_FRAME,
    ST_FLUSH
  } cam_state_t;

  localparam int WORD_W       = 128;
  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = 8;

  // RGB565 bars; index 0 is the leftmost band (white), index 7 the rightmost (black)
  localparam logic [7:0][15:0] COLOR_BAR = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

endpackage

// File: rtl/cam_colorbar_gen.sv
// rtl/cam_colorbar_gen.sv - 8-band colour-bar pixel source indexed by pixel position (used with CAM_TEST_PATTERN_EN)
module cam_colorbar_gen
  import cam_pkg::*;
#(
  parameter int H_PIXELS = 640,
  parameter int IDX_W    = $clog2(H_PIXELS + 1)
) (
  input  logic [IDX_W-1:0] i_pix_idx,
  output logic [PIX_W-1:0] o_pixel
);

  localparam int NUM_BANDS = 8;
  localparam int BAND_PIX  = H_PIXELS / NUM_BANDS;

  logic [2:0] w_band;

  // Band index from threshold compares so no divider is needed
  always_comb begin
    w_band = 3'd0;
    for (int b = 1; b < NUM_BANDS; b++) begin
      if (32'(i_pix_idx) >= 32'(b * BAND_PIX)) w_band = 3'(b);
    end
  end

  assign o_pixel = COLOR_BAR[w_band];

endmodule

// File: rtl/cam_pixel_packer.sv
// rtl/cam_pixel_packer.sv - DVP RGB565 byte stream to 128-bit FIFO words with frame/line status; optional CAM_TEST_PATTERN_EN colour bars
module cam_pixel_packer
  import cam_pkg::*;
#(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int FRAME_SKIP = 10
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
`ifdef CAM_TEST_PATTERN_EN
  input  logic              tp_sel,
`endif
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_wr_data,
  output logic              frame_start,
  output logic              line_done,
  output logic              frame_done,
  output logic              line_err,
  output logic              overflow
);

  localparam int LINE_BYTES = 2 * H_PIXELS;
  localparam int BYTE_W     = $clog2(LINE_BYTES + 2);
  localparam int LINE_W     = $clog2(V_LINES + 1);
  localparam int SKIP_W     = (FRAME_SKIP < 2) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam cam_state_t RST_STATE = (FRAME_SKIP == 0) ? ST_WAIT_VS : ST_SKIP;

  logic              r_vs, r_vs_d, r_href, r_href_d;
  logic [7:0]        r_data;
  cam_state_t        r_state, w_state_nxt;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic [LINE_W-1:0] r_line_cnt;
  logic [BYTE_W-1:0] r_byte_cnt;
  logic [2:0]        r_pix_cnt;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [WORD_W-1:0] r_acc;
  logic              r_wr_req;
  logic              r_frame_start, r_line_done, r_frame_done, r_line_err, r_overflow;
  logic              w_vs_rise, w_href_fall, w_line_full, w_last_line, w_start;
  logic [7:0]        w_byte;

  assign w_vs_rise   = r_vs & ~r_vs_d;
  // Href activity while vsync is high belongs to no line
  assign w_href_fall = r_href_d & ~r_href & ~r_vs;
  assign w_line_full = (r_byte_cnt == BYTE_W'(LINE_BYTES));
  assign w_last_line = (r_state == ST_FRAME) & w_href_fall & w_line_full &
                       (r_line_cnt == LINE_W'(V_LINES - 1));

`ifdef CAM_TEST_PATTERN_EN
  logic             r_tp_sel;
  logic [PIX_W-1:0] w_tp_pix;

  cam_colorbar_gen #(.H_PIXELS(H_PIXELS)) u_colorbar (
    .i_pix_idx (r_byte_cnt[BYTE_W-1:1]),
    .o_pixel   (w_tp_pix)
  );

  assign w_byte = !r_tp_sel ? r_data : (r_phase ? w_tp_pix[7:0] : w_tp_pix[15:8]);
`else
  assign w_byte = r_data;
`endif

  // Input capture plus a delayed copy for edge detection
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs     <= 1'b0;
      r_vs_d   <= 1'b0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
      r_data   <= 8'd0;
`ifdef CAM_TEST_PATTERN_EN
      r_tp_sel <= 1'b0;
`endif
    end else begin
      r_vs     <= cam_vsync;
      r_vs_d   <= r_vs;
      r_href   <= cam_href;
      r_href_d <= r_href;
      r_data   <= cam_data;
`ifdef CAM_TEST_PATTERN_EN
      r_tp_sel <= tp_sel;
`endif
    end
  end

  // Frame state register
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  // Next state; any vsync rise outside SKIP starts a new frame
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_SKIP: begin
        if (w_vs_rise && (32'(r_skip_cnt) + 32'd1 >= 32'(FRAME_SKIP))) w_state_nxt = ST_WAIT_VS;
      end
      ST_FRAME: begin
        if (w_vs_rise) begin
          w_state_nxt = ST_FRAME;
          w_start     = 1'b1;
        end else if (w_last_line) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        if (w_vs_rise) begin
          w_state_nxt = ST_FRAME;
          w_start     = 1'b1;
        end
      end
    endcase
  end

  // Byte pairing, word packing, line accounting and sticky status flags
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt    <= '0;
      r_line_cnt    <= '0;
      r_byte_cnt    <= '0;
      r_pix_cnt     <= 3'd0;
      r_phase       <= 1'b0;
      r_hi          <= 8'd0;
      r_acc         <= '0;
      r_wr_req      <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_err    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_wr_req      <= 1'b0;
      // fifo_full is judged in the strobe cycle itself; a blocked word is lost
      if (r_wr_req && fifo_full) r_overflow <= 1'b1;
      // Flags stay visible alongside frame_start, then clear
      if (r_frame_start) begin
        r_line_err <= 1'b0;
        r_overflow <= 1'b0;
      end
      if (r_state == ST_SKIP && w_vs_rise) r_skip_cnt <= r_skip_cnt + 1'b1;
      if (w_start) begin
        r_frame_start <= 1'b1;
        r_line_cnt    <= '0;
        r_byte_cnt    <= '0;
        r_pix_cnt     <= 3'd0;
        r_phase       <= 1'b0;
        if (r_state == ST_FRAME && (r_href || r_href_d || r_byte_cnt != '0)) r_line_err <= 1'b1;
      end else if (r_state == ST_FRAME && !r_vs) begin
        if (r_href) begin
          if (r_byte_cnt < BYTE_W'(LINE_BYTES)) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_phase    <= ~r_phase;
            if (!r_phase) begin
              r_hi <= w_byte;
            end else begin
              r_acc     <= {r_acc[WORD_W-PIX_W-1:0], r_hi, w_byte};
              r_pix_cnt <= r_pix_cnt + 1'b1;
              if (r_pix_cnt == 3'(PIX_PER_WORD - 1)) r_wr_req <= 1'b1;
            end
          end else begin
            // Over-long line: mark it and drop the excess bytes
            r_byte_cnt <= BYTE_W'(LINE_BYTES + 1);
          end
        end else if (w_href_fall) begin
          r_byte_cnt <= '0;
          r_pix_cnt  <= 3'd0;
          r_phase    <= 1'b0;
          if (w_line_full) begin
            r_line_done <= 1'b1;
            r_line_cnt  <= r_line_cnt + 1'b1;
            if (w_last_line) r_frame_done <= 1'b1;
          end else begin
            r_line_err <= 1'b1;
          end
        end
      end
    end
  end

  assign fifo_wr_en   = r_wr_req & ~fifo_full;
  assign fifo_wr_data = r_acc;
  assign frame_start  = r_frame_start;
  assign line_done    = r_line_done;
  assign frame_done   = r_frame_done;
  assign line_err     = r_line_err;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// tb/tb_cam_pixel_packer.sv - directed scoreboard bench for cam_pixel_packer
module tb_cam_pixel_packer;

  localparam int H    = 640;
  localparam int V    = 4;
  localparam int SKIP = 2;

  logic         cam_pclk = 1'b0;
  logic         rst_n, cam_vsync, cam_href, fifo_full;
  logic [7:0]   cam_data;
  logic         fifo_wr_en, frame_start, line_done, frame_done, line_err, overflow;
  logic [127:0] fifo_wr_data;
`ifdef CAM_TEST_PATTERN_EN
  logic         tp_sel = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int wr_cnt = 0, ld_cnt = 0, fd_cnt = 0, fs_cnt = 0;
  int last_wr_cyc = -10, ld_cyc = -1, fd_cyc = -2;
  int w0, l0;
  logic         le_at_fs = 1'b0;
  logic [127:0] first_word = '0;
  logic [127:0] exp_w;
  bit           cap_first = 1'b0;
  logic [127:0] exp_q[$];

  cam_pixel_packer #(.H_PIXELS(H), .V_LINES(V), .FRAME_SKIP(SKIP)) dut (
    .cam_pclk     (cam_pclk),
    .rst_n        (rst_n),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .cam_data     (cam_data),
`ifdef CAM_TEST_PATTERN_EN
    .tp_sel       (tp_sel),
`endif
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .frame_start  (frame_start),
    .line_done    (line_done),
    .frame_done   (frame_done),
    .line_err     (line_err),
    .overflow     (overflow)
  );

  always #5 cam_pclk = ~cam_pclk;

  always @(posedge cam_pclk) cyc++;

  // Output monitor: scoreboard pops on every write, event counters for pulses
  always @(negedge cam_pclk) begin
    if (fifo_wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (cap_first) begin
        first_word = fifo_wr_data;
        cap_first  = 1'b0;
      end
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected observed=%h expected=no write", fifo_wr_data);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        n_tests++;
        assert (fifo_wr_data === exp_w) else begin
          n_fail++;
          $error("FAIL wr_data observed=%h expected=%h", fifo_wr_data, exp_w);
        end
      end
    end
    if (line_done) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (frame_start) begin
      fs_cnt++;
      le_at_fs = line_err;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cam_pclk);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    tick(3);
    cam_vsync = 1'b0;
    tick(4);
  endtask

  // Drive nbytes of pixels first_pix, first_pix+1, ...; full_word >= 0 holds fifo_full over that word's strobe
  task automatic send_line(input int nbytes, input int first_pix, input int full_word,
                           input bit expect_wr, input bit drop_href);
    logic [127:0] w;
    logic [15:0]  pix;
    int           np;
    w  = '0;
    np = 0;
    for (int i = 0; i < nbytes; i++) begin
      pix       = 16'(first_pix + i / 2);
      cam_href  = 1'b1;
      cam_data  = (i % 2 == 0) ? pix[15:8] : pix[7:0];
      fifo_full = (full_word >= 0) && (i >= 16 * full_word + 14) && (i <= 16 * full_word + 20);
      if (i % 2 == 1) begin
        w = {w[111:0], pix};
        np++;
        if (np % 8 == 0 && expect_wr && i < 2 * H && (np / 8 - 1) != full_word) exp_q.push_back(w);
      end
      tick(1);
    end
    fifo_full = 1'b0;
    if (drop_href) begin
      cam_href = 1'b0;
      cam_data = 8'd0;
      tick(8);
    end
  endtask

  initial begin
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0; fifo_full = 1'b0;
    tick(3);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_line_done", line_done, 0);
    check("rst_line_err", line_err, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick(3);

    // Two settling frames: nothing may come out
    repeat (2) begin
      vsync_pulse();
      send_line(2 * H, 0, -1, 1'b0, 1'b1);
    end
    check("skip_wr", 128'(wr_cnt), 0);
    check("skip_fs", 128'(fs_cnt), 0);
    vsync_pulse();
    check("fs_third_vsync", 128'(fs_cnt), 1);

    // Line 0: pixels 0x0000..0x027F
    w0 = wr_cnt; l0 = ld_cnt; cap_first = 1'b1;
    send_line(2 * H, 0, -1, 1'b1, 1'b1);
    check("l0_writes", 128'(wr_cnt - w0), 80);
    check("l0_first_word", first_word, 128'h0000_0001_0002_0003_0004_0005_0006_0007);
    check("l0_line_done", 128'(ld_cnt - l0), 1);
    check("l0_ld_latency", 128'(ld_cyc - last_wr_cyc), 1);
    check("l0_line_err", line_err, 0);

    // Line 1: word 5 blocked by fifo_full
    w0 = wr_cnt; l0 = ld_cnt;
    send_line(2 * H, 16'h0100, 5, 1'b1, 1'b1);
    check("l1_writes", 128'(wr_cnt - w0), 79);
    check("l1_overflow", overflow, 1);
    check("l1_line_done", 128'(ld_cnt - l0), 1);
    check("l1_queue_empty", 128'(exp_q.size()), 0);

    // Short line of 1270 bytes
    w0 = wr_cnt; l0 = ld_cnt;
    send_line(1270, 16'h0300, -1, 1'b1, 1'b1);
    check("short_writes", 128'(wr_cnt - w0), 79);
    check("short_line_err", line_err, 1);
    check("short_no_line_done", 128'(ld_cnt - l0), 0);

    // Lines 2 and 3; frame_done only with the real 4th line
    l0 = ld_cnt;
    send_line(2 * H, 16'h0400, -1, 1'b1, 1'b1);
    check("l2_no_frame_done", 128'(fd_cnt), 0);
    send_line(2 * H, 16'h0480, -1, 1'b1, 1'b1);
    check("l3_frame_done", 128'(fd_cnt), 1);
    check("l3_fd_with_ld", 128'(fd_cyc - ld_cyc), 0);
    check("l23_line_done", 128'(ld_cnt - l0), 2);

    // Extra href after the last line is ignored
    w0 = wr_cnt; l0 = ld_cnt;
    send_line(2 * H, 0, -1, 1'b0, 1'b1);
    check("flush_writes", 128'(wr_cnt - w0), 0);
    check("flush_line_done", 128'(ld_cnt - l0), 0);

    // New frame clears sticky flags
    vsync_pulse();
    check("f2_frame_start", 128'(fs_cnt), 2);
    check("f2_line_err_clr", line_err, 0);
    check("f2_overflow_clr", overflow, 0);

    // Vsync rise after 100 bytes of a line
    le_at_fs = 1'b0;
    send_line(100, 16'h0500, -1, 1'b1, 1'b0);
    cam_vsync = 1'b1;
    tick(3);
    cam_href = 1'b0;
    tick(2);
    cam_vsync = 1'b0;
    tick(4);
    check("abort_frame_start", 128'(fs_cnt), 3);
    check("abort_err_pulse", le_at_fs, 1);
    check("abort_err_clr", line_err, 0);
    check("abort_queue_empty", 128'(exp_q.size()), 0);

    // Counters restarted: a clean full line
    w0 = wr_cnt; l0 = ld_cnt;
    send_line(2 * H, 16'h0580, -1, 1'b1, 1'b1);
    check("post_abort_writes", 128'(wr_cnt - w0), 80);
    check("post_abort_line_done", 128'(ld_cnt - l0), 1);
    check("post_abort_line_err", line_err, 0);

    // Over-long line: excess bytes dropped, flagged at href fall
    w0 = wr_cnt; l0 = ld_cnt;
    send_line(2 * H + 10, 16'h0600, -1, 1'b1, 1'b1);
    check("long_writes", 128'(wr_cnt - w0), 80);
    check("long_no_line_done", 128'(ld_cnt - l0), 0);
    check("long_line_err", line_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
